// File: rtl/hall_call_register.sv
// Debounces landing hall-call buttons into latched up/down request vectors, cleared by direction-matched door-open service, with stale flags.
// Latency: press visible after the DEBOUNCE_CYCLES-th high sample edge; clear one edge after service; all outputs registered.
module hall_call_register #(
  parameter int N_FLOORS        = 12,
  parameter int N_LIFTS         = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STALE_CYCLES    = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_FLOORS-1:0]         up_btn,
  input  logic [N_FLOORS-1:0]         dn_btn,
  input  logic [N_LIFTS*N_FLOORS-1:0] floor_sense,
  input  logic [N_LIFTS-1:0]          door_open,
  input  logic [N_LIFTS-1:0]          direction,
  output logic [N_FLOORS-1:0]         up_rqst,
  output logic [N_FLOORS-1:0]         dn_rqst,
  output logic [N_FLOORS-1:0]         up_stale,
  output logic [N_FLOORS-1:0]         dn_stale
);

  localparam int NCH = 2 * N_FLOORS;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW  = $clog2(STALE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } db_state_e;

  // Channel c < N_FLOORS is up[c]; channel N_FLOORS+f is dn[f].
  db_state_e       st_q  [NCH];
  db_state_e       st_d  [NCH];
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];
  logic [AW-1:0]   age_q [NCH];
  logic [AW-1:0]   age_d [NCH];
  logic [NCH-1:0]  rqst_q, rqst_d;
  logic [NCH-1:0]  stale_q, stale_d;
  logic [NCH-1:0]  btn_all, srv_all, chan_en;
  logic [N_FLOORS-1:0] up_served, dn_served;

  assign btn_all = {dn_btn, up_btn};
  assign srv_all = {dn_served, up_served};

  always_comb begin
    chan_en             = '1;
    chan_en[N_FLOORS-1] = 1'b0;
    chan_en[N_FLOORS]   = 1'b0;
  end

  // End floors serve regardless of direction: a lift can only leave one way.
  always_comb begin
    up_served = '0;
    dn_served = '0;
    for (int i = 0; i < N_LIFTS; i++) begin
      for (int f = 0; f < N_FLOORS; f++) begin
        if (floor_sense[i*N_FLOORS+f] && door_open[i]) begin
          if (direction[i] || f == 0)           up_served[f] = 1'b1;
          if (!direction[i] || f == N_FLOORS-1) dn_served[f] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic          acc;
    logic [CW-1:0] cnt_nxt;
    for (int c = 0; c < NCH; c++) begin
      st_d[c]    = st_q[c];
      cnt_d[c]   = cnt_q[c];
      rqst_d[c]  = rqst_q[c];
      age_d[c]   = age_q[c];
      acc        = 1'b0;
      cnt_nxt    = cnt_q[c] + CW'(1);

      case (st_q[c])
        IDLE: begin
          if (btn_all[c]) begin
            cnt_d[c] = CW'(1);
            if (DEBOUNCE_CYCLES == 1) begin
              st_d[c] = HELD;
              acc     = 1'b1;
            end else begin
              st_d[c] = COUNT;
            end
          end
        end
        COUNT: begin
          if (btn_all[c]) begin
            cnt_d[c] = cnt_nxt;
            if (cnt_nxt == CW'(DEBOUNCE_CYCLES)) begin
              st_d[c] = HELD;
              acc     = 1'b1;
            end
          end else begin
            st_d[c]  = IDLE;
            cnt_d[c] = '0;
          end
        end
        HELD: begin
          if (!btn_all[c]) begin
            st_d[c]  = IDLE;
            cnt_d[c] = '0;
          end
        end
        default: begin
          st_d[c]  = IDLE;
          cnt_d[c] = '0;
        end
      endcase

      // Service outranks a same-edge acceptance; a re-press of a pending call keeps its age.
      if (!chan_en[c] || srv_all[c]) begin
        rqst_d[c] = 1'b0;
        age_d[c]  = '0;
      end else if (acc && !rqst_q[c]) begin
        rqst_d[c] = 1'b1;
        age_d[c]  = '0;
      end else if (rqst_q[c] && age_q[c] != AW'(STALE_CYCLES)) begin
        age_d[c]  = age_q[c] + AW'(1);
      end

      stale_d[c] = rqst_d[c] && (age_d[c] == AW'(STALE_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rqst_q  <= '0;
      stale_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        st_q[c]  <= IDLE;
        cnt_q[c] <= '0;
        age_q[c] <= '0;
      end
    end else begin
      rqst_q  <= rqst_d;
      stale_q <= stale_d;
      for (int c = 0; c < NCH; c++) begin
        st_q[c]  <= st_d[c];
        cnt_q[c] <= cnt_d[c];
        age_q[c] <= age_d[c];
      end
    end
  end

  assign up_rqst  = rqst_q[N_FLOORS-1:0];
  assign dn_rqst  = rqst_q[NCH-1:N_FLOORS];
  assign up_stale = stale_q[N_FLOORS-1:0];
  assign dn_stale = stale_q[NCH-1:N_FLOORS];

endmodule

// File: tb/tb_hall_call_register.sv
// Scoreboarded bench for hall_call_register: directed scenarios then random traffic against a run-length/timestamp model.
module tb_hall_call_register;

  localparam int NF  = 12;
  localparam int NL  = 10;
  localparam int DB  = 4;
  localparam int ST  = 8;
  localparam int NCH = 2 * NF;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NF-1:0]     up_btn = '0;
  logic [NF-1:0]     dn_btn = '0;
  logic [NL*NF-1:0]  floor_sense = '0;
  logic [NL-1:0]     door_open = '0;
  logic [NL-1:0]     direction = '0;
  logic [NF-1:0]     up_rqst, dn_rqst, up_stale, dn_stale;

  int checks = 0;
  int errors = 0;

  // Reference state: consecutive-high run length, pending flag, cycle the call was latched.
  int  run     [NCH];
  bit  pend    [NCH];
  int  set_cyc [NCH];
  int  cyc = 0;
  logic [4*NF-1:0] sb_q [$];

  hall_call_register #(
    .N_FLOORS(NF), .N_LIFTS(NL), .DEBOUNCE_CYCLES(DB), .STALE_CYCLES(ST)
  ) dut (
    .clk(clk), .reset(reset), .up_btn(up_btn), .dn_btn(dn_btn),
    .floor_sense(floor_sense), .door_open(door_open), .direction(direction),
    .up_rqst(up_rqst), .dn_rqst(dn_rqst), .up_stale(up_stale), .dn_stale(dn_stale)
  );

  always #5 clk = ~clk;

  // Model the coming edge from the current inputs, queue the expectation, then take the edge.
  task automatic step();
    logic [NCH-1:0] btn, srv, r, s;
    logic [NF-1:0]  us, ds;
    int             fl;
    btn = {dn_btn, up_btn};
    us  = '0;
    ds  = '0;
    for (int i = 0; i < NL; i++) begin
      fl = -1;
      for (int f = 0; f < NF; f++) if (floor_sense[i*NF+f]) fl = f;
      if (fl >= 0 && door_open[i]) begin
        if (direction[i] || fl == 0)     us[fl] = 1'b1;
        if (!direction[i] || fl == NF-1) ds[fl] = 1'b1;
      end
    end
    srv = {ds, us};
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        run[c]  = 0;
        pend[c] = 1'b0;
      end else begin
        run[c] = btn[c] ? ((run[c] > DB) ? DB + 1 : run[c] + 1) : 0;
        if (srv[c]) pend[c] = 1'b0;
        else if (c != NF-1 && c != NF && run[c] == DB && !pend[c]) begin
          pend[c]    = 1'b1;
          set_cyc[c] = cyc;
        end
      end
      r[c] = pend[c];
      s[c] = pend[c] && (cyc - set_cyc[c] >= ST);
    end
    sb_q.push_back({s, r});
    cyc++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    logic [4*NF-1:0] e, g;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      g = {dn_stale, up_stale, dn_rqst, up_rqst};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d got {dn_stale,up_stale,dn_rqst,up_rqst}=%h expected %h",
                 cyc, g, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [NF-1:0] got, input logic [NF-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic put_lift(input int i, input int fl, input bit dopen, input bit dir);
    floor_sense[i*NF +: NF] = (fl >= 0 && fl < NF) ? (NF'(1) << fl) : '0;
    door_open[i] = dopen;
    direction[i] = dir;
  endtask

  task automatic clear_lifts();
    floor_sense = '0;
    door_open   = '0;
    direction   = '0;
  endtask

  initial begin
    logic [NCH-1:0] b;

    // Reset with every up button held.
    reset  = 1'b1;
    up_btn = '1;
    repeat (3) begin
      step();
      chk("reset_up_rqst", up_rqst, '0);
      chk("reset_up_stale", up_stale, '0);
    end
    reset = 1'b0;
    repeat (3) step();
    chk("post_reset_3", up_rqst, '0);
    step();
    chk("post_reset_4", up_rqst, 12'h7ff);
    up_btn = '0;
    for (int i = 0; i < NL; i++) put_lift(i, i, 1'b1, 1'b1);
    step();
    clear_lifts();
    put_lift(0, 10, 1'b1, 1'b1);
    step();
    clear_lifts();
    chk("sweep_clear", up_rqst, '0);

    // Glitch rejection on dn[5].
    dn_btn[5] = 1'b1; repeat (3) step();
    dn_btn[5] = 1'b0; step();
    dn_btn[5] = 1'b1; repeat (3) step();
    dn_btn[5] = 1'b0; step();
    chk("glitch_reject", dn_rqst, '0);
    dn_btn[5] = 1'b1; repeat (4) step();
    chk("glitch_accept", dn_rqst, 12'h020);
    dn_btn[5] = 1'b0; repeat (2) step();
    chk("glitch_hold", dn_rqst, 12'h020);
    put_lift(4, 5, 1'b1, 1'b0);
    step();
    clear_lifts();

    // Direction-qualified service at floor 3.
    up_btn[3] = 1'b1; dn_btn[3] = 1'b1;
    repeat (4) step();
    up_btn[3] = 1'b0; dn_btn[3] = 1'b0;
    step();
    chk("dir_setup_up", up_rqst, 12'h008);
    chk("dir_setup_dn", dn_rqst, 12'h008);
    put_lift(2, 3, 1'b1, 1'b0);
    step();
    chk("dir_down_dn", dn_rqst, '0);
    chk("dir_down_up", up_rqst, 12'h008);
    direction[2] = 1'b1;
    step();
    chk("dir_up_up", up_rqst, '0);
    clear_lifts();

    // Between-floor lift serves nothing; bottom floor serves up in any direction.
    up_btn[0] = 1'b1; repeat (4) step();
    up_btn[0] = 1'b0;
    put_lift(6, -1, 1'b1, 1'b1);
    step();
    chk("between_floors", up_rqst, 12'h001);
    put_lift(6, -1, 1'b0, 1'b0);
    put_lift(5, 0, 1'b1, 1'b0);
    step();
    chk("bottom_floor", up_rqst, '0);
    clear_lifts();

    // Acceptance coinciding with service.
    up_btn[7] = 1'b1; repeat (3) step();
    put_lift(0, 7, 1'b1, 1'b1);
    step();
    chk("simul_serve", up_rqst, '0);
    clear_lifts();
    repeat (5) step();
    chk("simul_no_relatch", up_rqst, '0);
    up_btn[7] = 1'b0; step();
    up_btn[7] = 1'b1; repeat (4) step();
    chk("simul_repress", up_rqst, 12'h080);
    up_btn[7] = 1'b0;
    put_lift(0, 7, 1'b1, 1'b1);
    step();
    clear_lifts();

    // Aging on dn[9].
    dn_btn[9] = 1'b1; repeat (4) step();
    dn_btn[9] = 1'b0;
    chk("stale_latched", dn_rqst, 12'h200);
    repeat (7) step();
    chk("stale_before", dn_stale, '0);
    step();
    chk("stale_at", dn_stale, 12'h200);
    repeat (3) step();
    chk("stale_hold", dn_stale, 12'h200);
    dn_btn[9] = 1'b1; repeat (4) step();
    dn_btn[9] = 1'b0; step();
    chk("stale_repress", dn_stale, 12'h200);
    put_lift(1, 9, 1'b1, 1'b0);
    step();
    chk("stale_srv_rqst", dn_rqst, '0);
    chk("stale_srv_flag", dn_stale, '0);
    clear_lifts();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      b = {dn_btn, up_btn};
      if ($urandom_range(0, 3) == 0) b[$urandom_range(0, NCH-1)] ^= 1'b1;
      {dn_btn, up_btn} = b;
      for (int i = 0; i < NL; i++)
        if ($urandom_range(0, 15) == 0)
          put_lift(i, $urandom_range(0, NF), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      step();
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d queued expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hall_call_register.md
# hall_call_register

Front-end stage for the multi-lift arbiter. It debounces raw landing hall-call buttons (up/down per floor) and latches them into stable `up_rqst`/`dn_rqst` vectors that feed the arbiter's request inputs. Each latched call is cleared when any lift stands at that floor with doors open, travelling in the call's direction. It also flags calls that have waited too long.

## Interface
- `N_FLOORS`, 12, number of floors; bit f of every floor vector is floor f, with floor 0 at the bottom.
- `N_LIFTS`, 10, number of lifts.
- `DEBOUNCE_CYCLES`, 4, consecutive high samples needed to accept a press; must be ≥1.
- `STALE_CYCLES`, 1024, pending cycles before a call is flagged stale; must be ≥1.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `up_btn` in N_FLOORS — raw up buttons; bit N_FLOORS-1 is ignored (no up button on the top floor).
- `dn_btn` in N_FLOORS — raw down buttons; bit 0 is ignored (no down button on the bottom floor).
- `floor_sense` in N_LIFTS*N_FLOORS — per-lift one-hot floor position; lift i occupies bits [i*N_FLOORS +: N_FLOORS]. An all-zero slice means the lift is between floors.
- `door_open` in N_LIFTS — lift i doors fully open.
- `direction` in N_LIFTS — lift i travel direction; 1 = up, 0 = down.
- `up_rqst` out N_FLOORS — latched up calls; drives the arbiter and the landing lamps.
- `dn_rqst` out N_FLOORS — latched down calls.
- `up_stale` out N_FLOORS — up call pending ≥ STALE_CYCLES cycles.
- `dn_stale` out N_FLOORS — down call pending ≥ STALE_CYCLES cycles.

## Operation
- There are 2*N_FLOORS independent button channels, except up[N_FLOORS-1] and dn[0]. Those two channels are tied off: their request and stale bits are constant 0.
- Each channel has a debounce FSM with a counter `cnt` of width clog2(DEBOUNCE_CYCLES+1):
  - IDLE: a high sample sets `cnt` = 1. If DEBOUNCE_CYCLES = 1, go straight to HELD and accept the press; otherwise go to COUNT.
  - COUNT: a high sample increments `cnt`. When `cnt` reaches DEBOUNCE_CYCLES, accept the press and go to HELD. A low sample returns to IDLE with `cnt` = 0.
  - HELD: stay while the button is high; return to IDLE on the first low sample. A press is accepted only once per physical push.
- Press accepted: set the request bit and clear the age counter. If the request bit is already set, the press has no effect and the age is not reset.
- Service:
  - `up_served[f]` = OR over all lifts i of (`floor_sense_i[f]` & `door_open[i]` & (`direction[i]` | f==0)).
  - `dn_served[f]` = OR over all lifts i of (`floor_sense_i[f]` & `door_open[i]` & (!`direction[i]` | f==N_FLOORS-1)).
  - A served request bit clears on the next edge, and its age and stale bits clear with it.
- Press accepted and service on the same edge: service wins and the request bit ends at 0. The FSM is in HELD, so a new call needs release and re-press.
- Service with no pending call has no effect.
- Aging:
  - Each pending channel has an age counter of width clog2(STALE_CYCLES+1). It increments every cycle the request bit is set and saturates at STALE_CYCLES.
  - stale = (age == STALE_CYCLES), registered.
- Between-floor lifts (all-zero slice) never serve any call.
- Multiple lifts serving the same floor in the same cycle is legal; the result is a single clear.

## Timing
- Reset (synchronous): all FSMs go to IDLE and all counters, `up_rqst`, `dn_rqst`, `up_stale`, `dn_stale` go to 0. This holds from the first edge with `reset` high, including mid-debounce or mid-service. A button held high through reset must count a full DEBOUNCE_CYCLES after reset deasserts.
- Press latency: `btn` is high from sample edge k onward. The request bit is 1 after edge k+DEBOUNCE_CYCLES-1, i.e. visible in the cycle after the DEBOUNCE_CYCLES-th high sample.
- Clear latency: a service condition sampled at edge k makes the request bit 0 after edge k.
- Stale latency: the request is set after edge k. Stale is 1 after edge k+STALE_CYCLES, provided no service occurs in between.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: drive `up_btn` = all ones and `reset` = 1 for 3 cycles. All outputs read 0 throughout. After release, `up_rqst[0..10]` are set exactly 4 cycles later; `up_rqst[11]` stays 0.
- Glitch rejection: `dn_btn[5]` high 3 cycles, low 1, high 3 → `dn_rqst[5]` stays 0. Then hold it high 4 cycles → `dn_rqst[5]` = 1 and stays 1 after release.
- Direction-qualified service:
  - Setup: `up_rqst[3]` and `dn_rqst[3]` are both pending.
  - Lift 2 at floor 3 with `door_open` = 1 and `direction` = 0 → only `dn_rqst[3]` clears.
  - Set `direction` = 1 → `up_rqst[3]` clears on the next edge.
- End floors and between-floors: a lift at floor 0 with `door_open` = 1 and `direction` = 0 clears `up_rqst[0]`. A lift with an all-zero floor slice and `door_open` = 1 clears nothing.
- Simultaneous press and service: the 4th high sample of `up_btn[7]` coincides with lift 0 serving up at floor 7 → `up_rqst[7]` = 0. Keeping the button held does not re-latch; release and re-press for 4 cycles → `up_rqst[7]` = 1.
- Stale: with STALE_CYCLES = 8, latch `dn_rqst[9]` → `dn_stale[9]` = 1 exactly 8 cycles later and stays 1. A re-press leaves it at 1. Service clears `dn_rqst[9]` and `dn_stale[9]` together on one edge.
